// File: rtl/watch_ctrl_fsm.sv
// watch_ctrl_fsm: control sequencer behind the debounced buttons of the
// stopwatch/clock design. In stopwatch mode it runs a STOP/RUN/CLEAR state
// machine. In clock-set mode it turns presses into sec/min/hour increment
// pulses.
// Optional feature macro: AUTO_REPEAT_EN. When it is defined, holding a set
// button auto-repeats its pulse after HOLD_CYC cycles, then every
// REPEAT_CYC cycles. When it is undefined, each press gives exactly one pulse.
// Button levels and sw_mode are registered once on entry. A level that is
// high at edge N therefore shows its effect on the outputs after edge N+1.
module watch_ctrl_fsm #(
    parameter int unsigned HOLD_CYC   = 50_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_mode,
    input  logic       btn_run,
    input  logic       btn_clear,
    input  logic       btn_sec,
    input  logic       btn_min,
    input  logic       btn_hour,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_inc_sec,
    output logic       o_inc_min,
    output logic       o_inc_hour,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_SEC,
        OWN_MIN,
        OWN_HOUR
    } owner_t;

    // Bit order for the button vectors: {hour, min, sec, clear, run}
    logic [4:0] lvl_q;
    logic [4:0] prev_q;
    logic [4:0] rise;
    logic       mode_q;
    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    logic [2:0] inc_q, inc_d;
    logic       owner_held;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CW = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          rep_q, rep_d;
    logic [CW-1:0] cnt_last;
    logic [2:0]    owner_mask;
`else
    logic unused_params;
    assign unused_params = ^{32'(HOLD_CYC), 32'(REPEAT_CYC)};
`endif

    // Register the button levels and mode. Keep the previous level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q  <= '0;
            prev_q <= '0;
            mode_q <= 1'b0;
        end else begin
            lvl_q  <= {btn_hour, btn_min, btn_sec, btn_clear, btn_run};
            prev_q <= lvl_q;
            mode_q <= sw_mode;
        end
    end

    assign rise = lvl_q & ~prev_q;

    // Stopwatch transitions. The state is frozen in set mode. CLEAR always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (!mode_q) begin
                    if (rise[0]) begin
                        state_d = ST_RUN;
                    end else if (rise[1]) begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_RUN: begin
                if (!mode_q && rise[0]) begin
                    state_d = ST_STOP;
                end
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    // Check whether the button that currently owns the set channel is still pressed.
    always_comb begin
        owner_held = 1'b0;
        case (owner_q)
            OWN_SEC:  owner_held = lvl_q[2];
            OWN_MIN:  owner_held = lvl_q[3];
            OWN_HOUR: owner_held = lvl_q[4];
            default:  owner_held = 1'b0;
        endcase
    end

`ifdef AUTO_REPEAT_EN
    // Select the pulse mask for the current owner and the count limit for the current phase.
    always_comb begin
        owner_mask = 3'b000;
        case (owner_q)
            OWN_SEC:  owner_mask = 3'b001;
            OWN_MIN:  owner_mask = 3'b010;
            OWN_HOUR: owner_mask = 3'b100;
            default:  owner_mask = 3'b000;
        endcase
        cnt_last = rep_q ? REPEAT_LAST : HOLD_LAST;
    end
`endif

    // Set-mode arbitration. The highest-priority rise is granted only when no owner exists. Losing rises are dropped.
    always_comb begin
        owner_d = owner_q;
        inc_d   = 3'b000;
`ifdef AUTO_REPEAT_EN
        cnt_d   = cnt_q;
        rep_d   = rep_q;
`endif
        if (!mode_q || (owner_q != OWN_NONE && !owner_held)) begin
            owner_d = OWN_NONE;
`ifdef AUTO_REPEAT_EN
            cnt_d   = '0;
            rep_d   = 1'b0;
`endif
        end else if (owner_q == OWN_NONE) begin
            if (rise[4]) begin
                owner_d = OWN_HOUR;
                inc_d   = 3'b100;
            end else if (rise[3]) begin
                owner_d = OWN_MIN;
                inc_d   = 3'b010;
            end else if (rise[2]) begin
                owner_d = OWN_SEC;
                inc_d   = 3'b001;
            end
`ifdef AUTO_REPEAT_EN
            cnt_d = '0;
            rep_d = 1'b0;
`endif
        end else begin
`ifdef AUTO_REPEAT_EN
            if (cnt_q == cnt_last) begin
                inc_d = owner_mask;
                cnt_d = '0;
                rep_d = 1'b1;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
`endif
        end
    end

    // State, owner and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            owner_q <= OWN_NONE;
            inc_q   <= 3'b000;
`ifdef AUTO_REPEAT_EN
            cnt_q   <= '0;
            rep_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            inc_q   <= inc_d;
`ifdef AUTO_REPEAT_EN
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
`endif
        end
    end

    assign o_state    = state_q;
    assign o_run      = (state_q == ST_RUN);
    assign o_clear    = (state_q == ST_CLEAR);
    assign o_inc_sec  = inc_q[0];
    assign o_inc_min  = inc_q[1];
    assign o_inc_hour = inc_q[2];

endmodule

// File: tb/tb_watch_ctrl_fsm.sv
// tb_watch_ctrl_fsm: self-checking bench for watch_ctrl_fsm.
// A behavioural model tracks the press age of each set button and the
// stopwatch mode. It is compared against the DUT on every falling edge.
// Directed literal checks pin the key cases, then a randomized phase follows.
// Build with AUTO_REPEAT_EN defined to exercise the auto-repeat variant.
module tb_watch_ctrl_fsm;

    localparam int unsigned HOLD = 8;
    localparam int unsigned REP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_mode = 1'b0;
    logic btn_run = 1'b0, btn_clear = 1'b0, btn_sec = 1'b0, btn_min = 1'b0, btn_hour = 1'b0;
    logic o_run, o_clear, o_inc_sec, o_inc_min, o_inc_hour;
    logic [1:0] o_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulseClr = 0, pulseSec = 0, pulseMin = 0, pulseHour = 0;
    int secOffsets[$];
    int startCyc = 0;
    bit recordSec = 1'b0;

    // Model state: 0 STOP, 1 RUN, 2 CLEAR. The owner index is 0 sec, 1 min, 2 hour, or -1 for none.
    int mState = 0;
    int owner  = -1;
    int age    = 0;
    bit [2:0] mInc = 3'b000;
    bit [5:0] lvl = 6'd0;
    bit [5:0] pv  = 6'd0;

    always #5 clk = ~clk;

    watch_ctrl_fsm #(.HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut (
        .clk(clk), .rst(rst), .sw_mode(sw_mode),
        .btn_run(btn_run), .btn_clear(btn_clear), .btn_sec(btn_sec),
        .btn_min(btn_min), .btn_hour(btn_hour),
        .o_run(o_run), .o_clear(o_clear), .o_inc_sec(o_inc_sec),
        .o_inc_min(o_inc_min), .o_inc_hour(o_inc_hour), .o_state(o_state)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hold the given inputs for n clock cycles. The vector b is {hour, min, sec, clear, run}.
    task automatic applyStimulus(input bit m, input bit [4:0] b, input int n);
        sw_mode = m;
        {btn_hour, btn_min, btn_sec, btn_clear, btn_run} = b;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural reference. Decisions use the levels seen one edge ago, so each response lands one edge later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mState = 0; owner = -1; age = 0; mInc = 3'b000; lvl = 6'd0; pv = 6'd0;
        end else begin : step
            bit [4:0] r;
            bit modeL;
            int g;
            r = lvl[4:0] & ~pv[4:0];
            modeL = lvl[5];
            if (mState == 2) mState = 0;
            else if (!modeL) begin
                if (mState == 0 && r[0]) mState = 1;
                else if (mState == 0 && r[1]) mState = 2;
                else if (mState == 1 && r[0]) mState = 0;
            end
            mInc = 3'b000;
            if (owner >= 0) begin
                if (modeL && lvl[2 + owner]) begin
                    age++;
`ifdef AUTO_REPEAT_EN
                    if (age == HOLD || (age > HOLD && (age - HOLD) % REP == 0)) mInc[owner] = 1'b1;
`endif
                end else begin
                    owner = -1;
                end
            end else if (modeL) begin
                g = r[4] ? 2 : (r[3] ? 1 : (r[2] ? 0 : -1));
                if (g >= 0) begin
                    owner = g; age = 0; mInc[g] = 1'b1;
                end
            end
            pv  = lvl;
            lvl = {sw_mode, btn_hour, btn_min, btn_sec, btn_clear, btn_run};
        end
    end

    // Compare every cycle and count the observed pulses.
    always @(negedge clk) begin
        checkOutput("o_state",    o_state,    mState);
        checkOutput("o_run",      o_run,      mState == 1);
        checkOutput("o_clear",    o_clear,    mState == 2);
        checkOutput("o_inc_sec",  o_inc_sec,  mInc[0]);
        checkOutput("o_inc_min",  o_inc_min,  mInc[1]);
        checkOutput("o_inc_hour", o_inc_hour, mInc[2]);
        pulseClr  += int'(o_clear);
        pulseSec  += int'(o_inc_sec);
        pulseMin  += int'(o_inc_min);
        pulseHour += int'(o_inc_hour);
        if (recordSec && o_inc_sec) secOffsets.push_back(cyc - startCyc);
    end

    initial begin : main
        int c0, s0, m0, h0, expN;
        int expOff[7];
`ifdef AUTO_REPEAT_EN
        expOff = '{1, 9, 13, 17, 21, 25, 29};
        expN = 7;
`else
        expOff = '{1, 0, 0, 0, 0, 0, 0};
        expN = 1;
`endif
        repeat (3) begin @(negedge clk); #1; end
        checkOutput("reset o_state", o_state, 0);
        checkOutput("reset o_run", o_run, 0);
        rst = 1'b0;
        applyStimulus(0, 5'b00000, 2);

        // Stopwatch FSM
        applyStimulus(0, 5'b00001, 1); applyStimulus(0, 5'b00000, 3);
        checkOutput("run press state", o_state, 1);
        checkOutput("run press o_run", o_run, 1);
        applyStimulus(0, 5'b00010, 1); applyStimulus(0, 5'b00000, 3);
        checkOutput("clear ignored in RUN", o_state, 1);
        applyStimulus(0, 5'b00001, 1); applyStimulus(0, 5'b00000, 3);
        checkOutput("stop press state", o_state, 0);
        c0 = pulseClr;
        applyStimulus(0, 5'b00010, 1); applyStimulus(0, 5'b00000, 5);
        checkOutput("clear pulse width", pulseClr - c0, 1);
        checkOutput("after clear state", o_state, 0);
        c0 = pulseClr;
        applyStimulus(0, 5'b00011, 1); applyStimulus(0, 5'b00000, 3);
        checkOutput("simultaneous run wins", o_state, 1);
        checkOutput("simultaneous no clear", pulseClr - c0, 0);

        // Set mode while the stopwatch runs in the background
        applyStimulus(1, 5'b00000, 3);
        checkOutput("set mode keeps run", o_run, 1);
        applyStimulus(1, 5'b00001, 1); applyStimulus(1, 5'b00000, 3);
        checkOutput("run ignored in set mode", o_state, 1);
        h0 = pulseHour;
        applyStimulus(1, 5'b10000, 1); applyStimulus(1, 5'b00000, 3);
        checkOutput("hour press pulse", pulseHour - h0, 1);
        h0 = pulseHour; s0 = pulseSec;
        applyStimulus(1, 5'b10100, 1); applyStimulus(1, 5'b00000, 3);
        checkOutput("hour beats sec", pulseHour - h0, 1);
        checkOutput("sec dropped", pulseSec - s0, 0);

        // Sec held for 30 cycles, with pulse offsets measured from the rise
        secOffsets.delete();
        btn_sec = 1'b1;
        @(posedge clk); #1;
        startCyc = cyc;
        recordSec = 1'b1;
        repeat (29) @(posedge clk);
        @(negedge clk); #1;
        btn_sec = 1'b0;
        applyStimulus(1, 5'b00000, 10);
        recordSec = 1'b0;
        checkOutput("sec hold pulse count", secOffsets.size(), expN);
        for (int i = 0; i < expN; i++)
            checkOutput($sformatf("sec offset %0d", i), (i < secOffsets.size()) ? secOffsets[i] : -1, expOff[i]);

        m0 = pulseMin;
        applyStimulus(1, 5'b01000, 30); applyStimulus(1, 5'b00000, 3);
        checkOutput("min hold pulse count", pulseMin - m0, expN);

        // Sec held across a switch back to stopwatch mode
        s0 = pulseSec;
        applyStimulus(1, 5'b00100, 3); applyStimulus(0, 5'b00100, 5); applyStimulus(0, 5'b00000, 3);
        checkOutput("sec across mode pulses", pulseSec - s0, 1);
        checkOutput("sec across mode state", o_state, 1);

        // Asynchronous reset mid-RUN with btn_run held
        applyStimulus(1, 5'b00001, 3); applyStimulus(0, 5'b00001, 3);
        checkOutput("held run no toggle", o_state, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset o_run", o_run, 0);
        checkOutput("async reset o_state", o_state, 0);
        checkOutput("async reset pulses", {o_clear, o_inc_sec, o_inc_min, o_inc_hour}, 0);
        applyStimulus(0, 5'b00001, 2);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post reset edge1 state", o_state, 0);
        @(posedge clk); #1;
        checkOutput("post reset edge2 state", o_state, 1);
        @(negedge clk); #1;
        applyStimulus(0, 5'b00000, 3);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) sw_mode = ~sw_mode;
            if ($urandom_range(0, 5) == 0) btn_run = ~btn_run;
            if ($urandom_range(0, 5) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(0, 11) == 0) btn_sec = ~btn_sec;
            if ($urandom_range(0, 11) == 0) btn_min = ~btn_min;
            if ($urandom_range(0, 11) == 0) btn_hour = ~btn_hour;
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk); #1;
        end
        rst = 1'b0;
        applyStimulus(0, 5'b00000, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
